vga_board_render: RTL and testbench

VGA_BOARD_RENDER -- requirements
Module: vga_board_render

---
 rtl/vga_board_if.sv | 11 +
 rtl/vga_board_render.sv | 169 ++++++++++++++++
 tb/tb_vga_board_render.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_board_if.sv
// Cell-write request bus for the board renderer: the requester drives a cell
// index and value, the renderer answers with wr_ready.
interface vga_board_if;
  logic       wr_valid;
  logic [3:0] wr_cell;
  logic [1:0] wr_val;
  logic       wr_ready;

  modport master (output wr_valid, output wr_cell, output wr_val, input wr_ready);
  modport slave  (input wr_valid, input wr_cell, input wr_val, output wr_ready);
endinterface

// File: rtl/vga_board_render.sv
// Draws a 3x3 game board over the VGA timing stream. Cell writes land in a shadow
// board that is copied to the displayed board on each vsync falling edge.
module vga_board_render #(
  parameter int GX0  = 170,
  parameter int GY0  = 90,
  parameter int CELL = 100,
  parameter int LINE = 2
) (
  input  logic        vgaclk,
  input  logic        rst,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        blank_b_i,
  vga_board_if.slave  wr,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        blank_b_o
);

  localparam logic [9:0] X0   = 10'(GX0);
  localparam logic [9:0] X1   = 10'(GX0 + CELL);
  localparam logic [9:0] X2   = 10'(GX0 + 2 * CELL);
  localparam logic [9:0] X3   = 10'(GX0 + 3 * CELL);
  localparam logic [9:0] Y0   = 10'(GY0);
  localparam logic [9:0] Y1   = 10'(GY0 + CELL);
  localparam logic [9:0] Y2   = 10'(GY0 + 2 * CELL);
  localparam logic [9:0] Y3   = 10'(GY0 + 3 * CELL);
  localparam logic [9:0] LW   = 10'(LINE);
  localparam logic [9:0] EDGE = 10'(CELL - LINE);

  function automatic logic [23:0] pick_colour(input logic blank_b, input logic in_grid,
                                              input logic line, input logic [1:0] st,
                                              input logic blink);
    if (!blank_b || !in_grid) return 24'h000000;
    if (line)                 return 24'hFFFFFF;
    case (st)
      2'd1:    return 24'hFF0000;
      2'd2:    return 24'h0000FF;
      2'd3:    return blink ? 24'hFFFF00 : 24'h000000;
      default: return 24'h000000;
    endcase
  endfunction

  // control state
  logic [8:0][1:0] shadow_q, shadow_d;
  logic [8:0][1:0] display_q, display_d;
  logic [4:0]      frm_q, frm_d;
  logic            vs_prev_q, vs_prev_d;
  logic            frame_evt;

  // stage 1 registers
  logic       hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d, blank_p1_q, blank_p1_d;
  logic       in_grid_p1_q, in_grid_p1_d;
  logic [1:0] col_p1_q, col_p1_d, row_p1_q, row_p1_d;
  logic [9:0] offx_p1_q, offx_p1_d, offy_p1_q, offy_p1_d;

  // stage 2 registers
  logic [23:0] rgb_p2_q, rgb_p2_d;
  logic        hs_p2_q, hs_p2_d, vs_p2_q, vs_p2_d, blank_p2_q, blank_p2_d;

  logic       line_p1;
  logic [3:0] cell_idx_p1;

  assign frame_evt   = vs_prev_q & ~vsync_i;
  assign wr.wr_ready = ~rst & ~frame_evt;

  always_comb begin
    shadow_d  = shadow_q;
    display_d = display_q;
    frm_d     = frm_q;
    vs_prev_d = vsync_i;
    if (frame_evt) begin
      display_d = shadow_q;
      frm_d     = frm_q + 5'd1;
    end else if (wr.wr_valid && (wr.wr_cell <= 4'd8)) begin
      shadow_d[wr.wr_cell] = wr.wr_val;
    end
  end

  // stage 0 -> 1: grid membership, cell coordinates and in-cell offsets
  always_comb begin
    hs_p1_d      = hsync_i;
    vs_p1_d      = vsync_i;
    blank_p1_d   = blank_b_i;
    in_grid_p1_d = (x >= X0) && (x < X3) && (y >= Y0) && (y < Y3);
    col_p1_d     = 2'd0;
    offx_p1_d    = x - X0;
    if (x >= X2) begin
      col_p1_d  = 2'd2;
      offx_p1_d = x - X2;
    end else if (x >= X1) begin
      col_p1_d  = 2'd1;
      offx_p1_d = x - X1;
    end
    row_p1_d  = 2'd0;
    offy_p1_d = y - Y0;
    if (y >= Y2) begin
      row_p1_d  = 2'd2;
      offy_p1_d = y - Y2;
    end else if (y >= Y1) begin
      row_p1_d  = 2'd1;
      offy_p1_d = y - Y1;
    end
  end

  // stage 1 -> 2: colour lookup; the far outer border is the tail of the last cell
  always_comb begin
    line_p1 = (offx_p1_q < LW) || (offy_p1_q < LW) ||
              ((col_p1_q == 2'd2) && (offx_p1_q >= EDGE)) ||
              ((row_p1_q == 2'd2) && (offy_p1_q >= EDGE));
    cell_idx_p1 = {2'b00, row_p1_q} + {2'b00, row_p1_q} + {2'b00, row_p1_q} + {2'b00, col_p1_q};
    rgb_p2_d   = pick_colour(blank_p1_q, in_grid_p1_q, line_p1,
                             display_q[cell_idx_p1], frm_q[4]);
    hs_p2_d    = hs_p1_q;
    vs_p2_d    = vs_p1_q;
    blank_p2_d = blank_p1_q;
  end

  always_ff @(posedge vgaclk) begin
    if (rst) begin
      shadow_q     <= '0;
      display_q    <= '0;
      frm_q        <= 5'd0;
      vs_prev_q    <= 1'b1;
      hs_p1_q      <= 1'b1;
      vs_p1_q      <= 1'b1;
      blank_p1_q   <= 1'b0;
      in_grid_p1_q <= 1'b0;
      col_p1_q     <= 2'd0;
      row_p1_q     <= 2'd0;
      offx_p1_q    <= 10'd0;
      offy_p1_q    <= 10'd0;
      rgb_p2_q     <= 24'h000000;
      hs_p2_q      <= 1'b1;
      vs_p2_q      <= 1'b1;
      blank_p2_q   <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      frm_q        <= frm_d;
      vs_prev_q    <= vs_prev_d;
      hs_p1_q      <= hs_p1_d;
      vs_p1_q      <= vs_p1_d;
      blank_p1_q   <= blank_p1_d;
      in_grid_p1_q <= in_grid_p1_d;
      col_p1_q     <= col_p1_d;
      row_p1_q     <= row_p1_d;
      offx_p1_q    <= offx_p1_d;
      offy_p1_q    <= offy_p1_d;
      rgb_p2_q     <= rgb_p2_d;
      hs_p2_q      <= hs_p2_d;
      vs_p2_q      <= vs_p2_d;
      blank_p2_q   <= blank_p2_d;
    end
  end

  assign r         = rgb_p2_q[23:16];
  assign g         = rgb_p2_q[15:8];
  assign b         = rgb_p2_q[7:0];
  assign hsync_o   = hs_p2_q;
  assign vsync_o   = vs_p2_q;
  assign blank_b_o = blank_p2_q;

endmodule

// File: tb/tb_vga_board_render.sv
// Randomized and directed bench for vga_board_render, checked against a
// frame-level model of the board that works from pixel arithmetic.
module tb_vga_board_render;
  localparam int GX0 = 170, GY0 = 90, CELL = 100, LINE = 2;

  logic       vgaclk = 1'b0;
  logic       rst;
  logic [9:0] x, y;
  logic       hsync_i, vsync_i, blank_b_i;
  logic [7:0] r, g, b;
  logic       hsync_o, vsync_o, blank_b_o;

  vga_board_if bus();

  vga_board_render #(.GX0(GX0), .GY0(GY0), .CELL(CELL), .LINE(LINE)) dut (
    .vgaclk(vgaclk), .rst(rst), .x(x), .y(y),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .blank_b_i(blank_b_i),
    .wr(bus), .r(r), .g(g), .b(b),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .blank_b_o(blank_b_o)
  );

  always #5 vgaclk = ~vgaclk;

  int n_checks = 0;
  int n_fail   = 0;

  // model of board contents and the pixel waiting in the first stage
  int m_shadow[9];
  int m_display[9];
  int m_frm;
  bit m_prev_vs;
  int p1_x, p1_y;
  bit p1_hs, p1_vs, p1_bl;

  logic [26:0] exp_vec, got_vec;
  logic        exp_ready, got_ready;

  function automatic logic [23:0] ref_colour(input int px, input int py, input bit bl);
    int lx, ly, st;
    if (!bl) return 24'h0;
    lx = px - GX0;
    ly = py - GY0;
    if (lx < 0 || lx >= 3 * CELL || ly < 0 || ly >= 3 * CELL) return 24'h0;
    if ((lx % CELL) < LINE || (ly % CELL) < LINE ||
        lx >= 3 * CELL - LINE || ly >= 3 * CELL - LINE) return 24'hFFFFFF;
    st = m_display[(ly / CELL) * 3 + lx / CELL];
    case (st)
      1: return 24'hFF0000;
      2: return 24'h0000FF;
      3: return ((m_frm / 16) % 2 == 1) ? 24'hFFFF00 : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  task automatic step();
    bit evt, c_rst, c_hs, c_vs, c_bl, c_wv;
    int c_x, c_y, c_cell, c_val;
    @(negedge vgaclk);
    c_rst = rst; c_x = int'(x); c_y = int'(y);
    c_hs = hsync_i; c_vs = vsync_i; c_bl = blank_b_i;
    c_wv = bus.wr_valid; c_cell = int'(bus.wr_cell); c_val = int'(bus.wr_val);
    evt = m_prev_vs && !c_vs;
    exp_ready = !c_rst && !evt;
    got_ready = bus.wr_ready;
    @(posedge vgaclk);
    if (c_rst) begin
      for (int i = 0; i < 9; i++) begin m_shadow[i] = 0; m_display[i] = 0; end
      m_frm = 0; m_prev_vs = 1'b1;
      p1_x = 0; p1_y = 0; p1_hs = 1'b1; p1_vs = 1'b1; p1_bl = 1'b0;
      exp_vec = {24'h0, 1'b1, 1'b1, 1'b0};
    end else begin
      exp_vec = {ref_colour(p1_x, p1_y, p1_bl), p1_hs, p1_vs, p1_bl};
      p1_x = c_x; p1_y = c_y; p1_hs = c_hs; p1_vs = c_vs; p1_bl = c_bl;
      if (evt) begin
        for (int i = 0; i < 9; i++) m_display[i] = m_shadow[i];
        m_frm = (m_frm + 1) % 32;
      end else if (c_wv && c_cell <= 8) begin
        m_shadow[c_cell] = c_val;
      end
      m_prev_vs = c_vs;
    end
    #1;
    got_vec = {r, g, b, hsync_o, vsync_o, blank_b_o};
  endtask

  task automatic frame_edge();
    vsync_i = 1'b0; step();
    vsync_i = 1'b1; step();
  endtask

  task automatic set_xy(input int px, input int py);
    x = 10'(px); y = 10'(py);
    step(); step();
  endtask

  task automatic test_reset();
    rst = 1'b1; x = 10'd320; y = 10'd240;
    hsync_i = 1'b1; vsync_i = 1'b1; blank_b_i = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_cell = 4'd0; bus.wr_val = 2'd0;
    step(); step();
    n_checks++;
    if (got_vec !== {24'h0, 3'b110}) begin
      n_fail++; $display("FAIL reset_outputs got=%h want=%h", got_vec, {24'h0, 3'b110});
    end
    n_checks++;
    if (got_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got=%b want=0", got_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_latency();
    x = 10'd0; y = 10'd0; blank_b_i = 1'b1; hsync_i = 1'b1;
    step(); step();
    hsync_i = 1'b0; step();
    n_checks++;
    if (got_vec[2] !== 1'b1) begin
      n_fail++; $display("FAIL latency_early got=%b want=1", got_vec[2]);
    end
    hsync_i = 1'b1; step();
    n_checks++;
    if (got_vec[26:2] !== {24'h0, 1'b0}) begin
      n_fail++; $display("FAIL latency_hsync got=%h want=%h", got_vec[26:2], {24'h0, 1'b0});
    end
    step();
    n_checks++;
    if (got_vec[2] !== 1'b1) begin
      n_fail++; $display("FAIL latency_release got=%b want=1", got_vec[2]);
    end
  endtask

  task automatic test_write_visible();
    x = 10'd320; y = 10'd240;
    bus.wr_valid = 1'b1; bus.wr_cell = 4'd4; bus.wr_val = 2'd1;
    step();
    bus.wr_valid = 1'b0;
    n_checks++;
    if (got_ready !== 1'b1) begin
      n_fail++; $display("FAIL write_ready got=%b want=1", got_ready);
    end
    step(); step();
    n_checks++;
    if (got_vec[26:3] !== 24'h0) begin
      n_fail++; $display("FAIL write_pre_frame got=%h want=000000", got_vec[26:3]);
    end
    frame_edge(); step(); step();
    n_checks++;
    if (got_vec[26:3] !== 24'hFF0000) begin
      n_fail++; $display("FAIL write_post_frame got=%h want=ff0000", got_vec[26:3]);
    end
  endtask

  task automatic test_grid_lines();
    int px[4] = '{170, 270, 469, 169};
    int py[4] = '{100, 240, 389, 240};
    logic [23:0] want[4] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};
    blank_b_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_xy(px[i], py[i]);
      n_checks++;
      if (got_vec[26:3] !== want[i]) begin
        n_fail++; $display("FAIL grid_line_%0d got=%h want=%h", i, got_vec[26:3], want[i]);
      end
    end
  endtask

  task automatic test_collision();
    x = 10'd220; y = 10'd140; vsync_i = 1'b1;
    step();
    vsync_i = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_cell = 4'd0; bus.wr_val = 2'd2;
    step();
    n_checks++;
    if (got_ready !== 1'b0) begin
      n_fail++; $display("FAIL collision_stall got=%b want=0", got_ready);
    end
    step();
    n_checks++;
    if (got_ready !== 1'b1) begin
      n_fail++; $display("FAIL collision_accept got=%b want=1", got_ready);
    end
    bus.wr_valid = 1'b0; vsync_i = 1'b1;
    step(); step();
    n_checks++;
    if (got_vec[26:3] !== 24'h0) begin
      n_fail++; $display("FAIL collision_pre_frame got=%h want=000000", got_vec[26:3]);
    end
    frame_edge(); step(); step();
    n_checks++;
    if (got_vec[26:3] !== 24'h0000FF) begin
      n_fail++; $display("FAIL collision_post_frame got=%h want=0000ff", got_vec[26:3]);
    end
  endtask

  task automatic test_blink_invalid();
    logic [23:0] want;
    bus.wr_valid = 1'b1; bus.wr_cell = 4'd8; bus.wr_val = 2'd3;
    step();
    bus.wr_valid = 1'b0;
    x = 10'd420; y = 10'd340;
    for (int f = 0; f < 34; f++) begin
      frame_edge(); step(); step();
      want = (m_frm >= 16) ? 24'hFFFF00 : 24'h0;
      n_checks++;
      if (got_vec[26:3] !== want) begin
        n_fail++; $display("FAIL blink_frame_%0d got=%h want=%h", m_frm, got_vec[26:3], want);
      end
    end
    bus.wr_valid = 1'b1; bus.wr_cell = 4'd12; bus.wr_val = 2'd1;
    step();
    bus.wr_valid = 1'b0;
    n_checks++;
    if (got_ready !== 1'b1) begin
      n_fail++; $display("FAIL invalid_ready got=%b want=1", got_ready);
    end
    frame_edge();
    for (int c = 0; c < 9; c++) begin
      set_xy(GX0 + (c % 3) * CELL + 50, GY0 + (c / 3) * CELL + 50);
      n_checks++;
      if (got_vec !== exp_vec) begin
        n_fail++; $display("FAIL invalid_cell_%0d got=%h want=%h", c, got_vec, exp_vec);
      end
    end
    set_xy(320, 240);
    n_checks++;
    if (got_vec[26:3] !== 24'hFF0000) begin
      n_fail++; $display("FAIL invalid_keeps_cell4 got=%h want=ff0000", got_vec[26:3]);
    end
  endtask

  task automatic test_reset_mid();
    x = 10'd320; y = 10'd240; blank_b_i = 1'b1;
    step();
    rst = 1'b1;
    step();
    n_checks++;
    if (got_vec !== {24'h0, 3'b110}) begin
      n_fail++; $display("FAIL midreset_outputs got=%h want=%h", got_vec, {24'h0, 3'b110});
    end
    n_checks++;
    if (got_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_ready got=%b want=0", got_ready);
    end
    rst = 1'b0;
    frame_edge();
    for (int c = 0; c < 9; c++) begin
      set_xy(GX0 + (c % 3) * CELL + 50, GY0 + (c / 3) * CELL + 50);
      n_checks++;
      if (got_vec[26:3] !== 24'h0) begin
        n_fail++; $display("FAIL midreset_cell_%0d got=%h want=000000", c, got_vec[26:3]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 149) == 0);
      x            = 10'($urandom_range(150, 489));
      y            = 10'($urandom_range(80, 409));
      blank_b_i    = ($urandom_range(0, 7) != 0);
      hsync_i      = 1'($urandom_range(0, 1));
      vsync_i      = ($urandom_range(0, 11) != 0);
      bus.wr_valid = ($urandom_range(0, 2) == 0);
      bus.wr_cell  = 4'($urandom_range(0, 15));
      bus.wr_val   = 2'($urandom_range(0, 3));
      step();
      n_checks++;
      if (got_vec !== exp_vec) begin
        n_fail++; $display("FAIL random_pixel_%0d got=%h want=%h", i, got_vec, exp_vec);
      end
      n_checks++;
      if (got_ready !== exp_ready) begin
        n_fail++; $display("FAIL random_ready_%0d got=%b want=%b", i, got_ready, exp_ready);
      end
    end
    rst = 1'b0; bus.wr_valid = 1'b0; vsync_i = 1'b1;
  endtask

  initial begin
    m_frm = 0; m_prev_vs = 1'b1;
    test_reset();
    test_latency();
    test_write_visible();
    test_grid_lines();
    test_collision();
    test_blink_invalid();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
